ks_note_sequencer: RTL and testbench

Programmable step sequencer that drives the Karplus-Strong string voice with `pluck` and `period` so melodies play without SPI traffic per note. It holds NUM_STEPS entries of {period, duration}. It plays them at a tempo derived from the sample-rate enable, the same clk_r16-rate tick that clocks the string. It sits directly upstream of ks_string: `pluck_o`/`period_o` replace the config-register pluck and period inputs when the sequencer is selected.

---
 rtl/ks_note_sequencer.sv | 149 ++++++++++++++
 tb/tb_ks_note_sequencer.sv | 472 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ks_note_sequencer.sv
// Step sequencer feeding the Karplus-Strong string: plays NUM_STEPS {period, duration}
// entries at a tempo derived from the string's sample-rate enable.
module ks_note_sequencer #(
  parameter int NUM_STEPS   = 8,
  parameter int DATA_WIDTH  = 8,
  parameter int TEMPO_WIDTH = 16,
  parameter int PLUCK_WIDTH = 4,
  localparam int STEP_W     = $clog2(NUM_STEPS)
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   tick_en_i,
  input  logic                   wr_en_i,
  input  logic [STEP_W-1:0]      wr_addr_i,
  input  logic [DATA_WIDTH-1:0]  wr_period_i,
  input  logic [DATA_WIDTH-1:0]  wr_dur_i,
  input  logic                   start_i,
  input  logic                   stop_i,
  input  logic                   loop_en_i,
  input  logic [STEP_W-1:0]      last_step_i,
  input  logic [TEMPO_WIDTH-1:0] tempo_div_i,
  input  logic [PLUCK_WIDTH-1:0] pluck_len_i,
  output logic                   pluck_o,
  output logic [DATA_WIDTH-1:0]  period_o,
  output logic [STEP_W-1:0]      step_o,
  output logic                   busy_o,
  output logic                   done_o,
  output logic [1:0]             state_o
);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_LOAD = 2'd1;
  localparam logic [1:0] ST_PLAY = 2'd2;
  localparam logic [1:0] ST_DONE = 2'd3;

  logic [1:0]             state;
  logic [DATA_WIDTH-1:0]  mem_period [NUM_STEPS];
  logic [DATA_WIDTH-1:0]  mem_dur    [NUM_STEPS];
  logic [TEMPO_WIDTH-1:0] tick_cnt;
  logic [DATA_WIDTH-1:0]  beat_left;
  logic [PLUCK_WIDTH-1:0] pluck_left;

  logic [DATA_WIDTH-1:0]  cur_period;
  logic [DATA_WIDTH-1:0]  cur_dur;
  logic                   beat_wrap;
  logic                   note_end;
  logic [1:0]             adv_state;
  logic [STEP_W-1:0]      adv_step;

  assign cur_period = mem_period[step_o];
  assign cur_dur    = mem_dur[step_o];
  // >= keeps the beat counter bounded if tempo_div_i is lowered mid-beat
  assign beat_wrap  = (tick_cnt >= tempo_div_i);
  assign note_end   = beat_wrap && (beat_left <= DATA_WIDTH'(1));

  assign busy_o  = (state != ST_IDLE);
  assign done_o  = (state == ST_DONE);
  assign state_o = state;

  // Where the sequence goes after the current step, using the live loop/last settings
  always_comb begin
    adv_state = ST_LOAD;
    adv_step  = step_o + STEP_W'(1);
    if (step_o == last_step_i) begin
      if (loop_en_i) begin
        adv_step = '0;
      end else begin
        adv_state = ST_DONE;
        adv_step  = step_o;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_STEPS; i++) begin
        mem_period[i] <= '0;
        mem_dur[i]    <= '0;
      end
    end else if (wr_en_i) begin
      mem_period[wr_addr_i] <= wr_period_i;
      mem_dur[wr_addr_i]    <= wr_dur_i;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= ST_IDLE;
      pluck_o    <= 1'b0;
      period_o   <= '0;
      step_o     <= '0;
      tick_cnt   <= '0;
      beat_left  <= '0;
      pluck_left <= '0;
    end else if (stop_i) begin
      state   <= ST_IDLE;
      pluck_o <= 1'b0;
    end else if (start_i) begin
      state   <= ST_LOAD;
      step_o  <= '0;
      pluck_o <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: pluck_o <= 1'b0;
        ST_LOAD: begin
          if (cur_dur == '0) begin
            pluck_o <= 1'b0;
            state   <= adv_state;
            step_o  <= adv_step;
          end else begin
            period_o   <= cur_period;
            pluck_o    <= 1'b1;
            tick_cnt   <= '0;
            beat_left  <= cur_dur;
            pluck_left <= pluck_len_i;
            state      <= ST_PLAY;
          end
        end
        ST_PLAY: begin
          if (tick_en_i) begin
            if (note_end) begin
              pluck_o <= 1'b0;
              state   <= adv_state;
              step_o  <= adv_step;
            end else begin
              if (beat_wrap) begin
                tick_cnt  <= '0;
                beat_left <= beat_left - DATA_WIDTH'(1);
              end else begin
                tick_cnt <= tick_cnt + TEMPO_WIDTH'(1);
              end
              if (pluck_left == '0) begin
                pluck_o <= 1'b0;
              end else begin
                pluck_left <= pluck_left - PLUCK_WIDTH'(1);
              end
            end
          end
        end
        ST_DONE: begin
          pluck_o <= 1'b0;
          state   <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ks_note_sequencer.sv
// Bench for ks_note_sequencer: a monitor turns pin activity into per-note records
// that are scored against a step-list model of the programmed melody.
module tb_ks_note_sequencer;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       tick_en_i;
  logic       wr_en_i;
  logic [2:0] wr_addr_i;
  logic [7:0] wr_period_i;
  logic [7:0] wr_dur_i;
  logic       start_i;
  logic       stop_i;
  logic       loop_en_i;
  logic [2:0] last_step_i;
  logic [15:0] tempo_div_i;
  logic [3:0] pluck_len_i;
  logic       pluck_o;
  logic [7:0] period_o;
  logic [2:0] step_o;
  logic       busy_o;
  logic       done_o;
  logic [1:0] state_o;

  ks_note_sequencer dut (
    .clk(clk), .rst_n(rst_n), .tick_en_i(tick_en_i), .wr_en_i(wr_en_i),
    .wr_addr_i(wr_addr_i), .wr_period_i(wr_period_i), .wr_dur_i(wr_dur_i),
    .start_i(start_i), .stop_i(stop_i), .loop_en_i(loop_en_i),
    .last_step_i(last_step_i), .tempo_div_i(tempo_div_i), .pluck_len_i(pluck_len_i),
    .pluck_o(pluck_o), .period_o(period_o), .step_o(step_o), .busy_o(busy_o),
    .done_o(done_o), .state_o(state_o)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // melody as programmed into the DUT
  int prog_period [8];
  int prog_dur    [8];

  // scoreboard: expected notes
  logic [7:0]  exp_period_q[$];
  logic [2:0]  exp_step_q[$];
  logic [15:0] exp_len_q[$];
  logic [15:0] exp_pl_q[$];

  // observed notes
  int obs_period_q[$];
  int obs_step_q[$];
  int obs_len_q[$];
  int obs_pl_q[$];
  int gap_q[$];
  int rise_cnt, done_cnt, step1_cnt;
  bit in_note;
  int cur_period, cur_step, cur_ticks, cur_pticks;
  bit pluck_prev = 1'b0;
  int low_run = 0;
  int tick_div = 0;

  task automatic close_note();
    obs_period_q.push_back(cur_period);
    obs_step_q.push_back(cur_step);
    obs_len_q.push_back(cur_ticks);
    obs_pl_q.push_back(cur_pticks);
    in_note = 1'b0;
  endtask

  // Tick generator and monitor share one process so the tick seen by the last edge is known
  initial begin
    tick_en_i = 1'b0;
    forever begin
      @(negedge clk);
      if (in_note && tick_en_i) begin
        cur_ticks++;
        if (pluck_prev) cur_pticks++;
      end
      if (done_o) begin
        done_cnt++;
        if (in_note) close_note();
      end
      if (pluck_o && !pluck_prev) begin
        if (in_note) close_note();
        gap_q.push_back(low_run);
        rise_cnt++;
        in_note    = 1'b1;
        cur_period = int'(period_o);
        cur_step   = int'(step_o);
        cur_ticks  = 0;
        cur_pticks = 0;
      end
      if (busy_o && step_o == 3'd1) step1_cnt++;
      low_run    = pluck_o ? 0 : low_run + 1;
      pluck_prev = pluck_o;
      tick_div   = (tick_div == 15) ? 0 : tick_div + 1;
      tick_en_i  = (tick_div == 0);
    end
  end

  task automatic step_clk();
    @(negedge clk);
    #1;
  endtask

  task automatic clear_obs();
    obs_period_q.delete();
    obs_step_q.delete();
    obs_len_q.delete();
    obs_pl_q.delete();
    gap_q.delete();
    rise_cnt  = 0;
    done_cnt  = 0;
    step1_cnt = 0;
    in_note   = 1'b0;
  endtask

  task automatic write_step(input int addr, input int per, input int dur);
    wr_en_i     = 1'b1;
    wr_addr_i   = 3'(addr);
    wr_period_i = 8'(per);
    wr_dur_i    = 8'(dur);
    step_clk();
    wr_en_i = 1'b0;
  endtask

  task automatic load_program();
    for (int i = 0; i < 8; i++) write_step(i, prog_period[i], prog_dur[i]);
  endtask

  task automatic set_basic();
    for (int i = 0; i < 8; i++) begin
      prog_period[i] = 0;
      prog_dur[i]    = 0;
    end
    prog_period[0] = 'h20; prog_dur[0] = 1;
    prog_period[1] = 'h30; prog_dur[1] = 2;
    prog_period[2] = 'h40; prog_dur[2] = 1;
  endtask

  // Walk the step list: each nonzero-duration step is one note of dur*(tempo+1) ticks
  task automatic build_expected(input int max_notes, output bit exp_done);
    int s, len, pl, n;
    exp_period_q.delete();
    exp_step_q.delete();
    exp_len_q.delete();
    exp_pl_q.delete();
    exp_done = 1'b0;
    s = 0;
    n = 0;
    for (int it = 0; it < 64; it++) begin
      if (prog_dur[s] != 0) begin
        len = prog_dur[s] * (int'(tempo_div_i) + 1);
        pl  = int'(pluck_len_i) + 1;
        exp_period_q.push_back(8'(prog_period[s]));
        exp_step_q.push_back(3'(s));
        exp_len_q.push_back(16'(len));
        exp_pl_q.push_back(16'((pl < len) ? pl : len));
        n++;
        if (n >= max_notes) break;
      end
      if (s == int'(last_step_i)) begin
        if (!loop_en_i) begin
          exp_done = 1'b1;
          break;
        end
        s = 0;
      end else begin
        s++;
      end
    end
  endtask

  task automatic play_and_check(input int max_notes);
    bit exp_done;
    int budget;
    logic [7:0] held_period;
    logic [2:0] held_step;
    build_expected(max_notes, exp_done);
    clear_obs();
    start_i = 1'b1;
    step_clk();
    start_i = 1'b0;
    budget = 0;
    while (budget < 5000 && (exp_done ? (done_cnt == 0) : (obs_period_q.size() < exp_period_q.size()))) begin
      step_clk();
      budget++;
    end
    checks++;
    if (budget >= 5000) begin
      errors++;
      $display("FAIL play_timeout notes=%0d done=%0d need notes=%0d", obs_period_q.size(), done_cnt, exp_period_q.size());
    end
    for (int i = 0; i < exp_period_q.size() && i < obs_period_q.size(); i++) begin
      checks++;
      if (obs_period_q[i] !== int'(exp_period_q[i])) begin
        errors++;
        $display("FAIL note_period[%0d] got %0h exp %0h", i, obs_period_q[i], exp_period_q[i]);
      end
      checks++;
      if (obs_step_q[i] !== int'(exp_step_q[i])) begin
        errors++;
        $display("FAIL note_step[%0d] got %0d exp %0d", i, obs_step_q[i], exp_step_q[i]);
      end
      checks++;
      if (obs_len_q[i] !== int'(exp_len_q[i])) begin
        errors++;
        $display("FAIL note_ticks[%0d] got %0d exp %0d", i, obs_len_q[i], exp_len_q[i]);
      end
      checks++;
      if (obs_pl_q[i] !== int'(exp_pl_q[i])) begin
        errors++;
        $display("FAIL pluck_ticks[%0d] got %0d exp %0d", i, obs_pl_q[i], exp_pl_q[i]);
      end
    end
    if (exp_done) begin
      step_clk();
      step_clk();
      checks++;
      if (obs_period_q.size() != exp_period_q.size()) begin
        errors++;
        $display("FAIL note_count got %0d exp %0d", obs_period_q.size(), exp_period_q.size());
      end
      checks++;
      if (done_cnt != 1) begin
        errors++;
        $display("FAIL done_pulse_clks got %0d exp 1", done_cnt);
      end
      checks++;
      if (busy_o !== 1'b0) begin
        errors++;
        $display("FAIL busy_after_done got %0b exp 0", busy_o);
      end
    end else begin
      checks++;
      if (done_cnt != 0 || busy_o !== 1'b1) begin
        errors++;
        $display("FAIL loop_running done=%0d busy=%0b exp done=0 busy=1", done_cnt, busy_o);
      end
      // abort a few clocks into the current note, while its pluck is still high
      step_clk();
      step_clk();
      held_period = period_o;
      held_step   = step_o;
      stop_i = 1'b1;
      step_clk();
      stop_i = 1'b0;
      checks++;
      if (busy_o !== 1'b0 || pluck_o !== 1'b0) begin
        errors++;
        $display("FAIL stop_idle busy=%0b pluck=%0b exp 0 0", busy_o, pluck_o);
      end
      checks++;
      if (period_o !== held_period || step_o !== held_step) begin
        errors++;
        $display("FAIL stop_hold period=%0h step=%0d exp %0h %0d", period_o, step_o, held_period, held_step);
      end
    end
  endtask

  task automatic test_reset();
    rst_n       = 1'b0;
    wr_en_i     = 1'($urandom_range(0, 1));
    wr_addr_i   = 3'($urandom_range(0, 7));
    wr_period_i = 8'($urandom_range(0, 255));
    wr_dur_i    = 8'($urandom_range(1, 255));
    start_i     = 1'($urandom_range(0, 1));
    stop_i      = 1'($urandom_range(0, 1));
    loop_en_i   = 1'($urandom_range(0, 1));
    last_step_i = 3'($urandom_range(0, 7));
    tempo_div_i = 16'($urandom_range(0, 65535));
    pluck_len_i = 4'($urandom_range(0, 15));
    step_clk();
    step_clk();
    rst_n   = 1'b1;
    wr_en_i = 1'b0;
    start_i = 1'b0;
    stop_i  = 1'b0;
    checks++;
    if (pluck_o !== 1'b0 || period_o !== 8'h00 || step_o !== 3'd0 || busy_o !== 1'b0 || done_o !== 1'b0) begin
      errors++;
      $display("FAIL reset_outputs pluck=%0b period=%0h step=%0d busy=%0b done=%0b exp all 0",
               pluck_o, period_o, step_o, busy_o, done_o);
    end
    // cleared memory: a full non-looping pass plays nothing and ends
    for (int i = 0; i < 8; i++) begin
      prog_period[i] = 0;
      prog_dur[i]    = 0;
    end
    loop_en_i   = 1'b0;
    last_step_i = 3'd7;
    tempo_div_i = 16'd0;
    pluck_len_i = 4'd0;
    play_and_check(8);
    checks++;
    if (rise_cnt != 0 || period_o !== 8'h00) begin
      errors++;
      $display("FAIL reset_memory plucks=%0d period=%0h exp 0 0", rise_cnt, period_o);
    end
  endtask

  task automatic test_basic();
    set_basic();
    load_program();
    loop_en_i   = 1'b0;
    last_step_i = 3'd2;
    tempo_div_i = 16'd3;
    pluck_len_i = 4'd0;
    play_and_check(8);
  endtask

  task automatic test_latency();
    clear_obs();
    start_i = 1'b1;
    step_clk();
    start_i = 1'b0;
    checks++;
    if (busy_o !== 1'b1 || pluck_o !== 1'b0) begin
      errors++;
      $display("FAIL latency_load busy=%0b pluck=%0b exp 1 0", busy_o, pluck_o);
    end
    step_clk();
    checks++;
    if (pluck_o !== 1'b1 || period_o !== 8'h20 || step_o !== 3'd0) begin
      errors++;
      $display("FAIL latency_play pluck=%0b period=%0h step=%0d exp 1 20 0", pluck_o, period_o, step_o);
    end
    stop_i = 1'b1;
    step_clk();
    stop_i = 1'b0;
  endtask

  task automatic test_loop_stop();
    set_basic();
    loop_en_i = 1'b1;
    play_and_check(4);
    loop_en_i = 1'b0;
  endtask

  task automatic test_skip();
    set_basic();
    prog_dur[1] = 0;
    write_step(1, prog_period[1], 0);
    last_step_i = 3'd2;
    play_and_check(8);
    checks++;
    if (rise_cnt != 2 || step1_cnt != 1) begin
      errors++;
      $display("FAIL skip_step plucks=%0d step1_clks=%0d exp 2 1", rise_cnt, step1_cnt);
    end
  endtask

  task automatic test_long_pluck();
    set_basic();
    prog_dur[1] = 1;
    load_program();
    tempo_div_i = 16'd3;
    pluck_len_i = 4'd7;
    play_and_check(8);
    for (int i = 1; i < gap_q.size(); i++) begin
      checks++;
      if (gap_q[i] != 1) begin
        errors++;
        $display("FAIL pluck_gap[%0d] got %0d clks exp 1", i, gap_q[i]);
      end
    end
    pluck_len_i = 4'd0;
  endtask

  task automatic test_start_stop_same();
    clear_obs();
    start_i = 1'b1;
    stop_i  = 1'b1;
    step_clk();
    start_i = 1'b0;
    stop_i  = 1'b0;
    checks++;
    if (busy_o !== 1'b0 || pluck_o !== 1'b0) begin
      errors++;
      $display("FAIL start_stop busy=%0b pluck=%0b exp 0 0", busy_o, pluck_o);
    end
    step_clk();
    step_clk();
    checks++;
    if (busy_o !== 1'b0 || rise_cnt != 0) begin
      errors++;
      $display("FAIL start_stop_later busy=%0b plucks=%0d exp 0 0", busy_o, rise_cnt);
    end
  endtask

  task automatic test_write_during_play();
    int budget;
    set_basic();
    load_program();
    loop_en_i   = 1'b1;
    last_step_i = 3'd2;
    tempo_div_i = 16'd3;
    clear_obs();
    start_i = 1'b1;
    step_clk();
    start_i = 1'b0;
    budget = 0;
    while (rise_cnt < 1 && budget < 200) begin
      step_clk();
      budget++;
    end
    write_step(0, 'h55, 1);
    checks++;
    if (period_o !== 8'h20) begin
      errors++;
      $display("FAIL write_live_note got %0h exp 20", period_o);
    end
    while (rise_cnt < 4 && budget < 2000) begin
      step_clk();
      budget++;
    end
    checks++;
    if (rise_cnt < 4 || period_o !== 8'h55 || step_o !== 3'd0) begin
      errors++;
      $display("FAIL write_reload period=%0h step=%0d plucks=%0d exp 55 0 4", period_o, step_o, rise_cnt);
    end
    checks++;
    if (obs_period_q.size() < 3 || obs_period_q[0] != 'h20 || obs_period_q[1] != 'h30 || obs_period_q[2] != 'h40) begin
      errors++;
      $display("FAIL write_first_pass notes=%0d exp 20 30 40", obs_period_q.size());
    end
    stop_i = 1'b1;
    step_clk();
    stop_i    = 1'b0;
    loop_en_i = 1'b0;
  endtask

  task automatic test_random();
    for (int i = 0; i < 8; i++) begin
      prog_period[i] = int'($urandom_range(1, 255));
      prog_dur[i]    = int'($urandom_range(0, 3));
    end
    load_program();
    loop_en_i   = 1'b0;
    last_step_i = 3'($urandom_range(0, 7));
    tempo_div_i = 16'($urandom_range(0, 3));
    pluck_len_i = 4'($urandom_range(0, 7));
    play_and_check(8);
  endtask

  initial begin
    rst_n       = 1'b0;
    wr_en_i     = 1'b0;
    wr_addr_i   = '0;
    wr_period_i = '0;
    wr_dur_i    = '0;
    start_i     = 1'b0;
    stop_i      = 1'b0;
    loop_en_i   = 1'b0;
    last_step_i = '0;
    tempo_div_i = '0;
    pluck_len_i = '0;
    clear_obs();
    test_reset();
    test_basic();
    test_latency();
    test_loop_stop();
    test_skip();
    test_long_pluck();
    test_start_stop_same();
    test_write_during_play();
    for (int r = 0; r < 4; r++) test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
